// File: rtl/oled_pkg.sv
// Shared definitions for the OLED SPI byte arbiter.
//   - requester index constants and default requester count
//   - arbiter FSM state encoding
//   - byte payload (D/C flag + data) as carried to SpiCtrl
package oled_pkg;

  localparam int unsigned NREQ_DEF = 3;

  // Requester slots on the arbiter.
  localparam int unsigned REQ_INIT = 0;  // init command stream
  localparam int unsigned REQ_PAGE = 1;  // page/column command stream
  localparam int unsigned REQ_PIX  = 2;  // pixel data stream

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned BCNT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_XFER    = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_e;

  // One byte as presented to SpiCtrl together with the OLED D/C level.
  typedef struct packed {
    logic              dc;
    logic [BYTE_W-1:0] data;
  } spi_byte_t;

  // Index width for n requesters, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_arbiter_rr_pick.sv
// Round-robin winner selection (purely combinational).
// Ports:
//   req   - per-requester request levels
//   last  - index of the previous owner; search starts at (last+1) mod NREQ
//   win   - one-hot winner, all-zero when nothing requests
//   valid - at least one request is present
module rr_pick
  import oled_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  localparam int unsigned IW  = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] win,
  output logic            valid
);

  logic [IW-1:0] w_k;

  // Walk the ring starting just after the previous owner; first hit wins.
  always_comb begin
    win   = '0;
    valid = 1'b0;
    w_k   = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      w_k = IW'((32'(last) + i) % NREQ);
      if (!valid && req[w_k]) begin
        win[w_k] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_arbiter.sv
// Byte-level arbiter sharing one SpiCtrl between several OLED command/data
// sources. Each grant moves one byte; a requester holding lock keeps the
// grant across consecutive bytes, capped at MAX_BURST while others wait.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   req, lock     - per-requester byte request and burst lock (levels)
//   data_in       - byte k on data_in[8k+7:8k]
//   dc_in         - per-requester D/C level (0 command, 1 data)
//   gnt           - one-hot current owner
//   done          - one-cycle pulse to the owner when its byte is out
//   spi_en        - start/hold strobe to SpiCtrl
//   spi_data, dc  - byte and D/C line presented to SpiCtrl / panel
//   spi_fin       - SpiCtrl byte-complete flag
//   busy          - arbiter is not idle
module spi_arbiter
  import oled_pkg::*;
#(
  parameter int unsigned NREQ      = NREQ_DEF,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        lock,
  input  logic [BYTE_W*NREQ-1:0] data_in,
  input  logic [NREQ-1:0]        dc_in,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        done,
  output logic                   spi_en,
  output logic [BYTE_W-1:0]      spi_data,
  input  logic                   spi_fin,
  output logic                   dc,
  output logic                   busy
);

  localparam int unsigned       IW        = idx_w(NREQ);
  localparam logic [BCNT_W-1:0] BURST_CAP = BCNT_W'(MAX_BURST);
  localparam logic [IW-1:0]     LAST_RST  = IW'(NREQ - 1);

  arb_state_e        r_state, w_state_nxt;
  logic [NREQ-1:0]   r_gnt, w_gnt_nxt;
  logic [NREQ-1:0]   r_done, w_done_nxt;
  logic              r_spi_en, w_spi_en_nxt;
  spi_byte_t         r_byte, w_byte_nxt;
  logic              r_busy, w_busy_nxt;
  logic [BCNT_W-1:0] r_bcnt, w_bcnt_nxt;
  logic [IW-1:0]     r_last, w_last_nxt;
  logic [IW-1:0]     r_owner, w_owner_nxt;

  spi_byte_t         w_bytes [NREQ];
  logic [NREQ-1:0]   w_win;
  logic              w_win_valid;
  logic [IW-1:0]     w_win_idx;
  logic              w_others;
  logic              w_cont;

  // Per-requester byte + D/C view of the flat input buses.
  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign w_bytes[g] = {dc_in[g], data_in[BYTE_W*g +: BYTE_W]};
  end

  rr_pick #(
    .NREQ (NREQ)
  ) u_rr_pick (
    .req   (req),
    .last  (r_last),
    .win   (w_win),
    .valid (w_win_valid)
  );

  // One-hot winner to index.
  always_comb begin
    w_win_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_win[i]) w_win_idx = IW'(i);
    end
  end

  // Burst continuation: owner still locked and requesting, and either under
  // the cap or nobody else is waiting (the cap only exists for fairness).
  assign w_others = |(req & ~r_gnt);
  assign w_cont   = lock[r_owner] & req[r_owner] &
                    ((r_bcnt < BURST_CAP) | ~w_others);

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_gnt    <= '0;
      r_done   <= '0;
      r_spi_en <= 1'b0;
      r_byte   <= '{dc: 1'b1, data: '0};
      r_busy   <= 1'b0;
      r_bcnt   <= '0;
      r_last   <= LAST_RST;
      r_owner  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_gnt    <= w_gnt_nxt;
      r_done   <= w_done_nxt;
      r_spi_en <= w_spi_en_nxt;
      r_byte   <= w_byte_nxt;
      r_busy   <= w_busy_nxt;
      r_bcnt   <= w_bcnt_nxt;
      r_last   <= w_last_nxt;
      r_owner  <= w_owner_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (w_win_valid) w_state_nxt = ST_LOAD;
      ST_LOAD:    w_state_nxt = ST_XFER;
      ST_XFER:    if (spi_fin) w_state_nxt = ST_RELEASE;
      ST_RELEASE: w_state_nxt = w_cont ? ST_LOAD : ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // Output / datapath next values. spi_en only rises from LOAD, so data and
  // D/C always settle one cycle ahead and spi_en drops for at least
  // RELEASE+LOAD between bytes.
  always_comb begin
    w_gnt_nxt    = r_gnt;
    w_done_nxt   = '0;
    w_spi_en_nxt = r_spi_en;
    w_byte_nxt   = r_byte;
    w_bcnt_nxt   = r_bcnt;
    w_last_nxt   = r_last;
    w_owner_nxt  = r_owner;
    w_busy_nxt   = (w_state_nxt != ST_IDLE);
    case (r_state)
      ST_IDLE: begin
        if (w_win_valid) begin
          w_gnt_nxt   = w_win;
          w_owner_nxt = w_win_idx;
          w_byte_nxt  = w_bytes[w_win_idx];
          w_bcnt_nxt  = '0;
        end
      end
      ST_LOAD: begin
        w_spi_en_nxt = 1'b1;
      end
      ST_XFER: begin
        if (spi_fin) begin
          w_spi_en_nxt = 1'b0;
          w_done_nxt   = r_gnt;
          if (r_bcnt < BURST_CAP) w_bcnt_nxt = r_bcnt + BCNT_W'(1);
        end
      end
      ST_RELEASE: begin
        if (w_cont) begin
          w_byte_nxt = w_bytes[r_owner];
        end else begin
          w_gnt_nxt  = '0;
          w_last_nxt = r_owner;
        end
      end
      default: begin
        w_gnt_nxt    = '0;
        w_spi_en_nxt = 1'b0;
      end
    endcase
  end

  assign gnt      = r_gnt;
  assign done     = r_done;
  assign spi_en   = r_spi_en;
  assign spi_data = r_byte.data;
  assign dc       = r_byte.dc;
  assign busy     = r_busy;

endmodule

// File: tb/tb_spi_arbiter.sv
// Self-checking bench for spi_arbiter: requesters are byte queues, a SpiCtrl
// model answers spi_en, and a transaction-level arbitration model predicts
// every grant, burst continuation and done pulse.
module tb_spi_arbiter;
  import oled_pkg::*;

  localparam int unsigned N  = 3;
  localparam int unsigned MB = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   lock = '0;
  logic [8*N-1:0] data_in = '0;
  logic [N-1:0]   dc_in = '0;
  logic [N-1:0]   gnt, done;
  logic           spi_en, spi_fin, dc, busy;
  logic [7:0]     spi_data;

  always #5 clk = ~clk;

  spi_arbiter #(.NREQ(N), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .data_in(data_in),
    .dc_in(dc_in), .gnt(gnt), .done(done), .spi_en(spi_en),
    .spi_data(spi_data), .spi_fin(spi_fin), .dc(dc), .busy(busy)
  );

  // SpiCtrl model: fin rises fin_n cycles after spi_en rises, held until
  // spi_en falls; optional spurious pulses while the arbiter is idle.
  int unsigned fin_cnt = 0, fin_n = 1, fin_lo = 1, fin_hi = 4;
  bit spur_en = 1'b0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      spi_fin <= 1'b0;
      fin_cnt <= 0;
    end else if (spi_en) begin
      if (fin_cnt + 1 >= fin_n) spi_fin <= 1'b1;
      else fin_cnt <= fin_cnt + 1;
    end else begin
      fin_cnt <= 0;
      fin_n   <= $urandom_range(fin_hi, fin_lo);
      spi_fin <= spur_en && (gnt == '0) && ($urandom_range(3, 0) == 0);
    end
  end

  typedef logic [8:0] tbyte_t;   // {dc, data}
  tbyte_t      q [N][$];
  bit          lk [N];
  int unsigned order [$];
  int unsigned exp_ord [$];
  int unsigned done_cnt [N];
  int unsigned m_last, m_owner, m_cnt;
  bit          dec_pending, rnd_on;
  logic [N-1:0] p_req, p_lock, p_gnt, p_done;
  logic        p_en;
  logic [8:0]  p_byte;
  int unsigned n_checks = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int unsigned k);
    logic [N-1:0] v;
    v = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  function automatic int unsigned idx_of(input logic [N-1:0] v);
    for (int unsigned i = 0; i < N; i++) if (v[i]) return i;
    return 0;
  endfunction

  // Round-robin rule: first requester found walking from last+1.
  function automatic logic [N-1:0] rr_expect(input logic [N-1:0] r, input int unsigned last);
    for (int unsigned i = 1; i <= N; i++) begin
      int unsigned k;
      k = (last + i) % N;
      if (r[k]) return onehot(k);
    end
    return '0;
  endfunction

  function automatic int unsigned pending();
    int unsigned s;
    s = (gnt != '0) ? 1 : 0;
    for (int k = 0; k < N; k++) s += q[k].size();
    return s;
  endfunction

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      req[k]  = (q[k].size() != 0);
      lock[k] = lk[k];
      if (q[k].size() != 0) begin
        data_in[8*k +: 8] = q[k][0][7:0];
        dc_in[k]          = q[k][0][8];
      end else begin
        data_in[8*k +: 8] = 8'($urandom);
        dc_in[k]          = 1'($urandom);
      end
    end
    p_req  = req;
    p_lock = lock;
  endtask

  task automatic monitor();
    logic [N-1:0] exp_g;
    bit others, cont;
    check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
    check("busy_vs_gnt", 32'(busy), 32'(|gnt));
    // Arbitration out of idle, using the request vector seen at that edge.
    if (p_gnt == '0 && (gnt != '0 || p_req != '0)) begin
      exp_g = rr_expect(p_req, m_last);
      check("grant_rr", 32'(gnt), 32'(exp_g));
      if (gnt != '0 && gnt == exp_g && q[idx_of(gnt)].size() != 0) begin
        m_owner = idx_of(gnt);
        m_cnt   = 0;
        order.push_back(m_owner);
        check("grant_byte", 32'({dc, spi_data}), 32'(q[m_owner][0]));
      end
    end
    if (spi_en && !p_en && q[m_owner].size() != 0) begin
      check("en_owner", 32'(gnt), 32'(onehot(m_owner)));
      check("en_setup", 32'({dc, spi_data}), 32'(p_byte));
      check("en_byte", 32'({dc, spi_data}), 32'(q[m_owner][0]));
    end
    if (spi_en && p_en) check("xfer_hold", 32'({dc, spi_data}), 32'(p_byte));
    // Burst decision taken the cycle after done.
    if (dec_pending) begin
      others = (p_req & ~onehot(m_owner)) != '0;
      cont   = p_lock[m_owner] && p_req[m_owner] && (m_cnt < MB || !others);
      check("release_gnt", 32'(gnt), cont ? 32'(onehot(m_owner)) : 32'd0);
      if (!cont) m_last = m_owner;
      dec_pending = 1'b0;
    end
    if (done != '0) begin
      check("done_owner", 32'(done), 32'(onehot(m_owner)));
      check("done_width", 32'(p_done), 32'd0);
      check("done_after_xfer", 32'(p_en), 32'd1);
      check("done_en_low", 32'(spi_en), 32'd0);
      if (q[m_owner].size() != 0) void'(q[m_owner].pop_front());
      done_cnt[m_owner]++;
      if (m_cnt < MB) m_cnt++;
      dec_pending = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (!rst) monitor();
    p_gnt  = gnt;
    p_done = done;
    p_en   = spi_en;
    p_byte = {dc, spi_data};
    if (rnd_on) begin
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(7, 0) == 0 && q[k].size() < 6) q[k].push_back(9'($urandom));
        if ($urandom_range(31, 0) == 0) lk[k] = ~lk[k];
      end
    end
    drive();
  endtask

  task automatic wait_drain(input int unsigned budget);
    for (int unsigned c = 0; c < budget; c++) begin
      step();
      if (pending() == 0 && !dec_pending) return;
    end
    check("drain_timeout", 32'(pending()), 32'd0);
  endtask

  task automatic wait_grants(input int unsigned n, input int unsigned budget);
    for (int unsigned c = 0; c < budget; c++) begin
      if (order.size() >= n) return;
      step();
    end
    check("grant_timeout", 32'(order.size()), 32'(n));
  endtask

  task automatic check_order(input string tag);
    check({tag, "_len"}, 32'(order.size()), 32'(exp_ord.size()));
    for (int i = 0; i < exp_ord.size() && i < order.size(); i++)
      check(tag, 32'(order[i]), 32'(exp_ord[i]));
    order.delete();
  endtask

  task automatic model_reset();
    m_last = N - 1; m_owner = 0; m_cnt = 0; dec_pending = 1'b0;
    p_gnt = '0; p_done = '0; p_en = 1'b0; p_byte = 9'h100;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rnd_on = 1'b0;
    for (int k = 0; k < N; k++) begin lk[k] = 1'b0; done_cnt[k] = 0; end
    model_reset();
    drive();
    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_en", 32'(spi_en), 32'd0);
    check("rst_data", 32'(spi_data), 32'd0);
    check("rst_dc", 32'(dc), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (3) step();

    // Single byte from the pixel requester.
    q[REQ_PIX].push_back({1'b1, 8'hA5});
    drive();
    wait_drain(100);
    exp_ord = '{2};
    check_order("single_order");
    check("single_done", 32'(done_cnt[2]), 32'd1);

    // Three-way contention, no lock: one byte per grant in ring order.
    for (int k = 0; k < N; k++) begin
      q[k].push_back({1'b0, 8'(8'h10 + k)});
      q[k].push_back({1'b1, 8'(8'h20 + k)});
    end
    drive();
    wait_drain(300);
    exp_ord = '{0, 1, 2, 0, 1, 2};
    check_order("contend_order");

    // Locked 3-byte command burst on requester 1; requester 0 waits.
    lk[1] = 1'b1;
    q[1].push_back({1'b0, 8'h22});
    q[1].push_back({1'b0, 8'h00});
    q[1].push_back({1'b0, 8'h07});
    drive();
    wait_grants(1, 50);
    q[0].push_back({1'b1, 8'h33});
    drive();
    wait_drain(300);
    lk[1] = 1'b0;
    exp_ord = '{1, 0};
    check_order("lock_order");

    // Burst cap with requester 0 waiting, then uncapped when alone.
    lk[2] = 1'b1;
    for (int i = 0; i < 6; i++) q[2].push_back({1'b1, 8'(8'hC0 + i)});
    done_cnt[2] = 0;
    drive();
    wait_grants(1, 50);
    q[0].push_back({1'b0, 8'h44});
    drive();
    wait_drain(500);
    exp_ord = '{2, 0, 2};
    check_order("cap_order");
    for (int i = 0; i < 6; i++) q[2].push_back({1'b1, 8'(8'hD0 + i)});
    drive();
    wait_drain(500);
    lk[2] = 1'b0;
    exp_ord = '{2};
    check_order("nocap_order");
    check("cap_bytes", 32'(done_cnt[2]), 32'd12);

    // Spurious fin while idle.
    spur_en = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      check("spur_quiet", 32'({busy, gnt, done}), 32'd0);
    end

    // Reset two cycles into a transfer.
    fin_lo = 8; fin_hi = 8;
    q[2].push_back({1'b0, 8'h5A});
    drive();
    for (int i = 0; i < 20 && !spi_en; i++) step();
    check("mid_reach_xfer", 32'(spi_en), 32'd1);
    step();
    step();
    rst = 1'b1;
    #1;
    check("mid_rst_en", 32'(spi_en), 32'd0);
    check("mid_rst_gnt", 32'(gnt), 32'd0);
    check("mid_rst_dc", 32'(dc), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    for (int k = 0; k < N; k++) begin q[k].delete(); lk[k] = 1'b0; end
    order.delete();
    step();
    check("mid_rst_nodone", 32'(done), 32'd0);
    fin_lo = 1; fin_hi = 4;
    model_reset();
    for (int k = 0; k < N; k++) q[k].push_back({1'b1, 8'(8'h60 + k)});
    drive();
    rst = 1'b0;
    wait_drain(300);
    exp_ord = '{0, 1, 2};
    check_order("post_rst_order");

    // Randomised traffic with random locks and SpiCtrl latency.
    rnd_on = 1'b1;
    for (int i = 0; i < 3000; i++) step();
    rnd_on = 1'b0;
    for (int k = 0; k < N; k++) lk[k] = 1'b0;
    wait_drain(3000);
    order.delete();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
